// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands and results are registered: fixed two-cycle request-to-response.
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [1:0]       req_alu_op_0,
  input  logic [1:0]       req_alu_op_1,
  input  logic [1:0]       req_f3_0,
  input  logic [1:0]       req_f3_1,
  input  logic [1:0]       req_f7_0,
  input  logic [1:0]       req_f7_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_f3,
  output logic [1:0]       alu_f7,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zf
);

  logic last_grant;
  logic s1_valid;
  logic s1_id;
  logic grant_0;
  logic grant_1;
  logic xfer;
  logic sel;

  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    unique case (1'b1)
      (req_valid_0 && req_valid_1): begin
        grant_0 = last_grant;
        grant_1 = !last_grant;
      end
      (req_valid_0 && !req_valid_1): grant_0 = 1'b1;
      (!req_valid_0 && req_valid_1): grant_1 = 1'b1;
      default: ;
    endcase
  end

  assign req_ready_0 = grant_0 && !flush;
  assign req_ready_1 = grant_1 && !flush;
  assign xfer        = req_ready_0 || req_ready_1;
  assign sel         = grant_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      s1_valid    <= 1'b0;
      s1_id       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_f3      <= '0;
      alu_f7      <= '0;
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_result  <= '0;
      rsp_carry   <= 1'b0;
      rsp_zf      <= 1'b0;
    end else if (flush) begin
      s1_valid    <= 1'b0;
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        last_grant <= sel;
        s1_id      <= sel;
        alu_a      <= sel ? req_a_1      : req_a_0;
        alu_b      <= sel ? req_b_1      : req_b_0;
        alu_op     <= sel ? req_alu_op_1 : req_alu_op_0;
        alu_f3     <= sel ? req_f3_1     : req_f3_0;
        alu_f7     <= sel ? req_f7_1     : req_f7_0;
      end
      rsp_valid_0 <= s1_valid && !s1_id;
      rsp_valid_1 <= s1_valid && s1_id;
      if (s1_valid) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zf     <= alu_zf;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
// Table rows are applied one per cycle; reset corner is hand-sequenced.
module tb_alu_arbiter;

  localparam int W = 64;
  localparam logic [W-1:0] Z = '0;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic req_valid_0 = 1'b0;
  logic req_valid_1 = 1'b0;
  logic req_ready_0, req_ready_1;
  logic [W-1:0] req_a_0 = '0, req_a_1 = '0;
  logic [W-1:0] req_b_0 = '0, req_b_1 = '0;
  logic [1:0] req_alu_op_0 = '0, req_alu_op_1 = '0;
  logic [1:0] req_f3_0 = '0, req_f3_1 = '0;
  logic [1:0] req_f7_0 = '0, req_f7_1 = '0;
  logic rsp_valid_0, rsp_valid_1;
  logic [W-1:0] rsp_result;
  logic rsp_carry, rsp_zf;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0] alu_op, alu_f3, alu_f7;
  logic [W-1:0] alu_result;
  logic alu_carry, alu_zf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_alu_op_0(req_alu_op_0), .req_alu_op_1(req_alu_op_1),
    .req_f3_0(req_f3_0), .req_f3_1(req_f3_1),
    .req_f7_0(req_f7_0), .req_f7_1(req_f7_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_zf(rsp_zf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_f3(alu_f3), .alu_f7(alu_f7),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zf(alu_zf)
  );

  // 00 add, 01 sub (carry = no borrow), 10 and, 11 xor
  logic [W:0] sum;
  always_comb begin
    sum = '0;
    alu_carry = 1'b0;
    case (alu_op)
      2'd0: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = sum[W];
      end
      2'd1: begin
        sum = {1'b0, alu_a - alu_b};
        alu_carry = (alu_a >= alu_b);
      end
      2'd2: sum = {1'b0, alu_a & alu_b};
      default: sum = {1'b0, alu_a ^ alu_b};
    endcase
    alu_result = sum[W-1:0];
    alu_zf = (alu_result == '0);
  end

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic v0, v1;
    logic [W-1:0] a0, b0;
    logic [1:0] op0;
    logic [W-1:0] a1, b1;
    logic [1:0] op1;
    logic fl;
    logic er0, er1;
    logic ev0, ev1;
    logic chk;
    logic [W-1:0] res;
    logic cy, zf;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 64'd32, 64'd1, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, Z, Z, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, Z, Z, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b1, 64'h21, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, Z, Z, 2'd0,
                64'd33, 64'd33, 2'd1, 1'b0, 1'b0, 1'b1,
                1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0};
    tbl[4]  = tbl[1];
    tbl[5]  = '{1'b0, 1'b0, Z, Z, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b1, Z, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 64'd5, 64'd3, 2'd0,
                64'd10, 64'd4, 2'd1, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 64'd7, 64'd7, 2'd1,
                64'hF0, 64'h3C, 2'd2, 1'b0, 1'b0, 1'b1,
                1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 64'd1, 64'd2, 2'd0,
                64'd9, 64'd9, 2'd3, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b1, 64'd8, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 64'd1, 64'd2, 2'd0,
                64'd9, 64'd9, 2'd3, 1'b0, 1'b0, 1'b1,
                1'b0, 1'b1, 1'b1, 64'h30, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 64'd100, 64'd1, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b1, 64'd3, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, Z, Z, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b1, Z, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, ONES, 64'd2, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b1, 64'd101, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 64'd4, 64'd4, 2'd3,
                MSB, 64'd1, 2'd1, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, Z, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 64'd4, 64'd4, 2'd3,
                MSB, 64'd1, 2'd1, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b1, 64'd1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, Z, Z, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b1, MAXP, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, Z, Z, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b1, Z, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, Z, Z, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b1, Z, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 64'd3, 64'd4, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b1, Z, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 64'd10, 64'd10, 2'd0,
                Z, Z, 2'd0, 1'b1, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b1, Z, 1'b0, 1'b1};
    tbl[20] = tbl[17];
    tbl[21] = '{1'b1, 1'b0, 64'd6, 64'd7, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b1, Z, 1'b0, 1'b1};
    tbl[22] = tbl[17];
    tbl[23] = '{1'b0, 1'b0, Z, Z, 2'd0,
                Z, Z, 2'd0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b1, 64'd13, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst alu_a", alu_a, Z);
    check("rst alu_op", {62'd0, alu_op}, Z);
    check("rst rsp_result", rsp_result, Z);
    check("rst rsp_valid", {62'd0, rsp_valid_1, rsp_valid_0}, Z);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req_valid_0  = tbl[i].v0;
      req_valid_1  = tbl[i].v1;
      req_a_0      = tbl[i].a0;
      req_b_0      = tbl[i].b0;
      req_alu_op_0 = tbl[i].op0;
      req_a_1      = tbl[i].a1;
      req_b_1      = tbl[i].b1;
      req_alu_op_1 = tbl[i].op1;
      flush        = tbl[i].fl;
      #1;
      check($sformatf("row%0d ready0", i),
            {63'd0, req_ready_0}, {63'd0, tbl[i].er0});
      check($sformatf("row%0d ready1", i),
            {63'd0, req_ready_1}, {63'd0, tbl[i].er1});
      check($sformatf("row%0d rsp_valid_0", i),
            {63'd0, rsp_valid_0}, {63'd0, tbl[i].ev0});
      check($sformatf("row%0d rsp_valid_1", i),
            {63'd0, rsp_valid_1}, {63'd0, tbl[i].ev1});
      if (tbl[i].chk) begin
        check($sformatf("row%0d result", i), rsp_result, tbl[i].res);
        check($sformatf("row%0d carry", i),
              {63'd0, rsp_carry}, {63'd0, tbl[i].cy});
        check($sformatf("row%0d zf", i),
              {63'd0, rsp_zf}, {63'd0, tbl[i].zf});
      end
    end

    // Reset in the middle of a cycle with an op sitting in stage 1.
    @(negedge clk);
    req_valid_1 = 1'b1;
    req_a_1 = 64'd1;
    req_b_1 = 64'd1;
    req_alu_op_1 = 2'd0;
    req_f3_1 = 2'b01;
    req_f7_1 = 2'b10;
    @(negedge clk);
    req_valid_1 = 1'b0;
    req_valid_0 = 1'b1;
    req_a_0 = 64'd11;
    req_b_0 = 64'd22;
    req_alu_op_0 = 2'd0;
    req_f3_0 = 2'b10;
    req_f7_0 = 2'b01;
    #1;
    check("r1 alu_a", alu_a, 64'd1);
    check("r1 alu_f3", {62'd0, alu_f3}, 64'd1);
    check("r1 alu_f7", {62'd0, alu_f7}, 64'd2);
    @(posedge clk);
    #2;
    check("r0 alu_a", alu_a, 64'd11);
    check("r0 alu_b", alu_b, 64'd22);
    check("r0 alu_f3", {62'd0, alu_f3}, 64'd2);
    check("r0 alu_f7", {62'd0, alu_f7}, 64'd1);
    check("r1 rsp_valid_1", {63'd0, rsp_valid_1}, 64'd1);
    check("r1 rsp_result", rsp_result, 64'd2);
    rst_n = 1'b0;
    #1;
    check("async alu_a", alu_a, Z);
    check("async alu_b", alu_b, Z);
    check("async alu_ctl",
          {58'd0, alu_op, alu_f3, alu_f7}, Z);
    check("async rsp_result", rsp_result, Z);
    check("async flags",
          {60'd0, rsp_carry, rsp_zf, rsp_valid_1, rsp_valid_0}, Z);
    @(negedge clk);
    req_valid_0 = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post-rst%0d rsp_valid", k),
            {62'd0, rsp_valid_1, rsp_valid_0}, Z);
    end
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    #1;
    check("post-rst ready0", {63'd0, req_ready_0}, 64'd1);
    check("post-rst ready1", {63'd0, req_ready_1}, 64'd0);
    @(negedge clk);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
